// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: FSM encodings, funct3 access codes, byte enables.
package lsu_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_H0   = 4'b0011;
   localparam logic [3:0] BE_H1   = 4'b1100;
   localparam logic [3:0] BE_W    = 4'b1111;

   function automatic logic f3_legal(input logic [2:0] f3, input logic [1:0] off);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_BU: ok = 1'b1;
         F3_H, F3_HU: ok = ~off[0];
         F3_W:        ok = (off == 2'b00);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: store byte-enable/data packing, legality check, load lane select and extension.
// Zero latency; no flow control of its own.
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DATAWIDTH = 32
) (
   input  logic [2:0]           funct3,
   input  logic [1:0]           offset,
   input  logic [DATAWIDTH-1:0] store_data,
   output logic [3:0]           be,
   output logic [DATAWIDTH-1:0] wdata,
   output logic                 legal,
   input  logic [2:0]           ld_funct3,
   input  logic [1:0]           ld_offset,
   input  logic [DATAWIDTH-1:0] rdata,
   output logic [DATAWIDTH-1:0] load_ext
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign legal = f3_legal(funct3, offset);

   always_comb begin
      be    = BE_NONE;
      wdata = store_data;
      case (funct3[1:0])
         2'b00: begin
            be    = BE_B0 << offset;
            wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            be    = offset[1] ? BE_H1 : BE_H0;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = BE_W;
            wdata = store_data;
         end
      endcase
   end

   always_comb begin
      ld_byte = rdata[7:0];
      case (ld_offset)
         2'd0:    ld_byte = rdata[7:0];
         2'd1:    ld_byte = rdata[15:8];
         2'd2:    ld_byte = rdata[23:16];
         default: ld_byte = rdata[31:24];
      endcase
      ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_ext = rdata;
      case (ld_funct3)
         F3_B:    load_ext = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   load_ext = {24'd0, ld_byte};
         F3_H:    load_ext = {{16{ld_half[15]}}, ld_half};
         F3_HU:   load_ext = {16'd0, ld_half};
         default: load_ext = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: IDLE->REQ->DONE req/ready access to data memory; min 3-cycle latency, +1 per mem_ready=0 cycle.
// Stalls the core while an access is outstanding; LSU_TIMEOUT_EN adds a bounded wait that aborts with addr_err.
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int DATAWIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 MemRead,
   input  logic                 MemWrite,
   input  logic [2:0]           funct3,
   input  logic [DATAWIDTH-1:0] addr,
   input  logic [DATAWIDTH-1:0] storeData,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [DATAWIDTH-1:0] mem_addr,
   output logic [3:0]           mem_be,
   output logic [DATAWIDTH-1:0] mem_wdata,
   input  logic                 mem_ready,
   input  logic [DATAWIDTH-1:0] mem_rdata,
   output logic                 stall,
   output logic [DATAWIDTH-1:0] loadData,
   output logic                 loadValid,
   output logic                 addr_err
);

   if (DATAWIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("lsu_unit: DATAWIDTH must be 32 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]           state;
   logic                 ld_op;
   logic [2:0]           ld_f3;
   logic [1:0]           ld_off;
   logic [3:0]           be;
   logic [DATAWIDTH-1:0] wdata;
   logic [DATAWIDTH-1:0] load_ext;
   logic                 legal;
   logic                 access;

   assign access = MemRead | MemWrite;

   lsu_lane_align #(.DATAWIDTH(DATAWIDTH)) u_align (
      .funct3     (funct3),
      .offset     (addr[1:0]),
      .store_data (storeData),
      .be         (be),
      .wdata      (wdata),
      .legal      (legal),
      .ld_funct3  (ld_f3),
      .ld_offset  (ld_off),
      .rdata      (mem_rdata),
      .load_ext   (load_ext)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_hit;

   // Fires on the edge that ends the TIMEOUT_CYCLES-th ready-low REQ cycle.
   assign tmo_hit = (state == ST_REQ) && !mem_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state != ST_REQ) begin
         tmo_cnt <= '0;
      end else if (!mem_ready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`endif

   // An illegal access never stalls: it is dropped and flagged instead.
   always_comb begin
      stall = 1'b0;
      case (state)
         ST_IDLE: stall = access & legal;
         ST_REQ:  stall = 1'b1;
         default: stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= BE_NONE;
         mem_wdata <= '0;
         loadData  <= '0;
         loadValid <= 1'b0;
         addr_err  <= 1'b0;
         ld_op     <= 1'b0;
         ld_f3     <= F3_W;
         ld_off    <= 2'b00;
      end else begin
         loadValid <= 1'b0;
         addr_err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access) begin
                  if (legal) begin
                     mem_req   <= 1'b1;
                     mem_we    <= MemWrite;
                     mem_addr  <= {addr[DATAWIDTH-1:2], 2'b00};
                     mem_be    <= be;
                     mem_wdata <= wdata;
                     ld_op     <= MemRead & ~MemWrite;
                     ld_f3     <= funct3;
                     ld_off    <= addr[1:0];
                     state     <= ST_REQ;
                  end else begin
                     addr_err <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (ld_op) begin
                     loadData  <= load_ext;
                     loadValid <= 1'b1;
                  end
                  state <= ST_DONE;
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmo_hit) begin
                  mem_req  <= 1'b0;
                  mem_we   <= 1'b0;
                  addr_err <= 1'b1;
                  loadData <= '0;
                  state    <= ST_DONE;
               end
`endif
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: loads, stores, lane extension, illegal accesses, wait states, mid-access reset.
module tb_lsu_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        MemRead, MemWrite;
   logic [2:0]  funct3;
   logic [31:0] addr, storeData;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        stall;
   logic [31:0] loadData;
   logic        loadValid, addr_err;

   always #5 clk = ~clk;

   lsu_unit #(.DATAWIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .funct3    (funct3),
      .addr      (addr),
      .storeData (storeData),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .stall     (stall),
      .loadData  (loadData),
      .loadValid (loadValid),
      .addr_err  (addr_err)
   );

   int passed = 0;
   int total  = 0;

   logic        c_req, c_we;
   logic [31:0] c_addr, c_wdata;
   logic [3:0]  c_be;
   int          c_stalls, c_unstable;
   logic        d_valid, d_stall, d_req, i_req, i_valid;
   logic [31:0] d_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Accept, nwait ready-low REQ cycles, ready cycle, DONE, then one IDLE cycle with the instruction still held.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] word, input int nwait);
      MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; storeData = sd; mem_ready = 1'b0;
      #1;
      c_stalls = stall ? 1 : 0;
      tick;
      c_req = mem_req; c_we = mem_we; c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wdata;
      if (stall) c_stalls++;
      c_unstable = 0;
      for (int i = 0; i < nwait; i++) begin
         tick;
         if (stall) c_stalls++;
         if (mem_req !== 1'b1 || mem_we !== c_we || mem_addr !== c_addr ||
             mem_be !== c_be || mem_wdata !== c_wdata) c_unstable++;
      end
      mem_ready = 1'b1; mem_rdata = word;
      tick;
      d_valid = loadValid; d_data = loadData; d_stall = stall; d_req = mem_req;
      mem_ready = 1'b0; mem_rdata = 32'h0BAD_F00D;
      tick;
      i_req = mem_req; i_valid = loadValid;
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b010;
      addr = '0; storeData = '0; mem_ready = 1'b0; mem_rdata = '0;
      #2;
      chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
      chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
      chk("rst_mem_addr",  mem_addr,           32'd0);
      chk("rst_mem_be",    {28'd0, mem_be},    32'd0);
      chk("rst_mem_wdata", mem_wdata,          32'd0);
      chk("rst_loadData",  loadData,           32'd0);
      chk("rst_loadValid", {31'd0, loadValid}, 32'd0);
      chk("rst_addr_err",  {31'd0, addr_err},  32'd0);
      #5 rst_n = 1'b1;
      tick;

      access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      chk("lw_req",      {31'd0, c_req},   32'd1);
      chk("lw_we",       {31'd0, c_we},    32'd0);
      chk("lw_addr",     c_addr,           32'h100);
      chk("lw_be",       {28'd0, c_be},    32'hF);
      chk("lw_stalls",   c_stalls,         32'd2);
      chk("lw_valid",    {31'd0, d_valid}, 32'd1);
      chk("lw_data",     d_data,           32'hDEADBEEF);
      chk("lw_done_stall", {31'd0, d_stall}, 32'd0);
      chk("lw_done_req", {31'd0, d_req},   32'd0);
      chk("lw_no_reaccept", {31'd0, i_req}, 32'd0);
      chk("lw_valid_pulse", {31'd0, i_valid}, 32'd0);

      access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
      chk("lb_addr", c_addr, 32'h100);
      chk("lb_be",   {28'd0, c_be}, 32'h8);
      chk("lb_data", d_data, 32'hFFFFFF80);
      access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0);
      chk("lbu_data", d_data, 32'h00000080);

      access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFF_FFFF, 0);
      chk("sh_we",    {31'd0, c_we}, 32'd1);
      chk("sh_be",    {28'd0, c_be}, 32'hC);
      chk("sh_wdata", c_wdata, 32'hABCDABCD);
      chk("sh_addr",  c_addr, 32'h200);
      chk("sh_no_valid", {31'd0, d_valid}, 32'd0);
      chk("sh_loaddata_held", d_data, 32'h00000080);

      access(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000005A, 32'h0, 0);
      chk("sb_be",    {28'd0, c_be}, 32'h2);
      chk("sb_wdata", c_wdata, 32'h5A5A5A5A);

      access(1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h1111_1111, 0);
      chk("rw_we",    {31'd0, c_we}, 32'd1);
      chk("rw_wdata", c_wdata, 32'hCAFEF00D);
      chk("rw_no_valid", {31'd0, d_valid}, 32'd0);
      chk("rw_loaddata_held", d_data, 32'h00000080);

      MemRead = 1'b1; funct3 = 3'b010; addr = 32'h101;
      #1;
      chk("mis_stall", {31'd0, stall}, 32'd0);
      tick;
      chk("mis_err",  {31'd0, addr_err}, 32'd1);
      chk("mis_req",  {31'd0, mem_req},  32'd0);
      MemRead = 1'b0;
      tick;
      chk("mis_err_pulse", {31'd0, addr_err}, 32'd0);
      chk("mis_req_after", {31'd0, mem_req},  32'd0);

      MemRead = 1'b1; funct3 = 3'b011; addr = 32'h0;
      tick;
      chk("f3_011_err", {31'd0, addr_err}, 32'd1);
      chk("f3_011_req", {31'd0, mem_req},  32'd0);
      MemRead = 1'b0;
      tick;

      access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'h0000_8001, 5);
      chk("lh_wait_stable", c_unstable, 32'd0);
      chk("lh_wait_stalls", c_stalls, 32'd7);
      chk("lh_wait_addr", c_addr, 32'h10);
      chk("lh_wait_valid", {31'd0, d_valid}, 32'd1);
      chk("lh_wait_data", d_data, 32'hFFFF8001);

      MemRead = 1'b1; funct3 = 3'b001; addr = 32'h10; mem_ready = 1'b0;
      tick;
      chk("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
      MemRead = 1'b0;
      #1;
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;
      tick;

      access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'hF00D_0000, 0);
      chk("lhu_after_rst_addr", c_addr, 32'h10);
      chk("lhu_after_rst_data", d_data, 32'h0000F00D);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout bench did not finish");
      $fatal(1);
   end

endmodule
